muldiv_ctrl: RTL and testbench
==============================

// Module: muldiv_ctrl
// PURPOSE
//  Sequencer for the multi-cycle MULT/MULTU/DIV/DIVU unit in the EXE stage.
//  Latches operands on the decoder's start, runs a fixed-latency multiplier or a
//  32-step iterative divider, stalls the pipeline while busy, and delivers the
//  HI/LO result for the RHL write path (RHLSel_Wr = 2'b10). Handles exception
//  flush mid-operation.
// PARAMETERS
//  MUL_LAT  2  number of cycles spent in MUL state (>=1); models the multiplier pipeline depth
// PORTS
//  clk      in   1   system clock
//  rst      in   1   asynchronous, active-low reset
//  start    in   1   EXE-stage mult/div instruction valid (decoder start, already qualified)
//  ALU2Op   in   2   00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//  A        in   32  rs operand
//  B        in   32  rt operand
//  flush    in   1   exception/eret flush; aborts any operation
//  busy     out  1   stall request to IF/ID/EXE
//  done     out  1   one-cycle pulse: hi/lo valid, RHL write this cycle
//  hi       out  32  HI result (remainder for div)
//  lo       out  32  LO result (quotient for div)
// BEHAVIOUR
//  Reset (rst low, async): state=IDLE, hi=lo=0, done=0, counters 0; busy=0 while rst low.
//  States: IDLE, MUL, DIV, DONE.
//  IDLE: start && !flush -> latch A,B,ALU2Op; ALU2Op[1]=0 -> MUL (cnt=MUL_LAT-1);
//   ALU2Op[1]=1 && B!=0 -> DIV (cnt=31); ALU2Op[1]=1 && B==0 -> DONE directly.
//  MUL: cnt decrements each cycle; cnt==0 -> DONE. Product: full 64-bit,
//   signed (MULT) or unsigned (MULTU); hi=prod[63:32], lo=prod[31:0].
//  DIV: restoring shift-subtract on magnitudes, one quotient bit per cycle;
//   32 cycles, then DONE. Signed DIV: quotient sign = A[31]^B[31], remainder
//   sign = A[31]; 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0 (falls out of magnitude math).
//  Divide by zero (either signedness): hi=A, lo=32'hFFFF_FFFF, no exception.
//  DONE: done=1 for exactly this cycle; hi/lo registers updated on entry to DONE.
//   start in DONE -> accept new op (same rules as IDLE), else -> IDLE.
//  busy = (state==MUL || state==DIV) || (state==IDLE && start && !flush).
//   busy=0 in DONE so the issuing instruction retires on the done cycle.
//  Latency (start cycle = 0): MUL -> done at cycle MUL_LAT+1; DIV -> done at cycle 33;
//   div-by-zero -> done at cycle 1.
//  flush: highest priority in every state; next state IDLE, no done pulse, hi/lo
//   unchanged, busy=0 the same cycle; flush && start same cycle -> start ignored.
//  hi/lo hold last completed result until the next done; aborted ops never write them.
//  Operand inputs ignored outside IDLE/DONE acceptance cycles.
// STRUCTURE
//  ALU2Op encodings, state encodings, DIV_STEPS=32 go in MacroDef.v as `defines.
//  Sub-module div_iter: 32-bit restoring divider datapath (load, step, 64-bit
//   rem/quot shift register, unsigned magnitudes in, quotient/remainder out);
//   muldiv_ctrl owns FSM, counters, sign fix-up, multiplier and result regs.
// TESTING
//  MULT A=0xFFFFFFFE, B=3 -> done at cycle MUL_LAT+1, hi=0xFFFFFFFF, lo=0xFFFFFFFA; busy high cycles 0..MUL_LAT.
//  MULTU A=B=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
//  DIV A=0xFFFFFFF9(-7), B=2 -> done at cycle 33, lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU same operands -> lo=0x7FFFFFFC, hi=1.
//  DIVU A=7, B=0 -> done at cycle 1, hi=7, lo=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
//  flush at cycle 10 of DIV -> busy 0 same cycle, no done, hi/lo unchanged; start next cycle completes normally.
//  start asserted in DONE cycle -> second op accepted without IDLE gap; rst low mid-DIV -> all outputs 0 immediately.

Source files
------------

// File: rtl/muldiv_ctrl_pkg.sv
// Shared types and constants for the MULT/MULTU/DIV/DIVU sequencer.
package muldiv_ctrl_pkg;

   typedef enum logic [1:0] {
      OP_MULTU = 2'b00,
      OP_MULT  = 2'b01,
      OP_DIVU  = 2'b10,
      OP_DIV   = 2'b11
   } alu2op_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MUL,
      ST_DIV,
      ST_DONE
   } state_e;

   localparam int unsigned DIV_STEPS = 32;

   function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
      return neg ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/muldiv_ctrl_div_iter.sv
// 32-bit restoring divider datapath: one quotient bit per step on unsigned magnitudes.
// step_quot/step_rem present the state after the current step so the last step can be captured directly.
module muldiv_ctrl_div_iter
   import muldiv_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic        step,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   output logic [31:0] step_quot,
   output logic [31:0] step_rem
);

   logic [63:0] rq_q, rq_d;
   logic [31:0] dvs_q, dvs_d;
   logic [63:0] rq_step;
   logic [32:0] sh_rem;
   logic [32:0] trial;

   always_comb begin
      sh_rem  = rq_q[63:31];
      trial   = sh_rem - {1'b0, dvs_q};
      // a non-negative trial difference restores nothing and sets the quotient bit
      if (!trial[32]) rq_step = {trial[31:0], rq_q[30:0], 1'b1};
      else            rq_step = {sh_rem[31:0], rq_q[30:0], 1'b0};
   end

   always_comb begin
      rq_d  = rq_q;
      dvs_d = dvs_q;
      if (load) begin
         rq_d  = {32'd0, dividend};
         dvs_d = divisor;
      end else if (step) begin
         rq_d  = rq_step;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rq_q  <= '0;
         dvs_q <= '0;
      end else begin
         rq_q  <= rq_d;
         dvs_q <= dvs_d;
      end
   end

   assign step_quot = rq_step[31:0];
   assign step_rem  = rq_step[63:32];

endmodule

// File: rtl/muldiv_ctrl.sv
// EXE-stage sequencer for MULT/MULTU/DIV/DIVU: latches operands, stalls while busy,
// and delivers HI/LO with a one-cycle done pulse; flush aborts without touching HI/LO.
module muldiv_ctrl
   import muldiv_ctrl_pkg::*;
#(
   parameter int unsigned MUL_LAT = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [1:0]  ALU2Op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        flush,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int unsigned CNT_MAX = (MUL_LAT > DIV_STEPS) ? MUL_LAT : DIV_STEPS;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX);
   localparam logic [CNT_W-1:0] MUL_CNT0 = CNT_W'(MUL_LAT - 1);
   localparam logic [CNT_W-1:0] DIV_CNT0 = CNT_W'(DIV_STEPS - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
   logic             sgn_q, sgn_d;

   alu2op_e          op_in;
   logic             in_div, in_sgn;
   logic             div_load, div_step;
   logic [31:0]      div_quot, div_rem;
   logic [63:0]      ext_a, ext_b, prod;

   assign op_in  = alu2op_e'(ALU2Op);
   assign in_div = (op_in == OP_DIVU) || (op_in == OP_DIV);
   assign in_sgn = (op_in == OP_MULT) || (op_in == OP_DIV);

   muldiv_ctrl_div_iter u_div (
      .clk       (clk),
      .rst       (rst),
      .load      (div_load),
      .step      (div_step),
      .dividend  (cond_neg(A, in_sgn & A[31])),
      .divisor   (cond_neg(B, in_sgn & B[31])),
      .step_quot (div_quot),
      .step_rem  (div_rem)
   );

   always_comb begin
      ext_a = sgn_q ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
      ext_b = sgn_q ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
      prod  = ext_a * ext_b;
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      a_d      = a_q;
      b_d      = b_q;
      sgn_d    = sgn_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      div_load = 1'b0;
      div_step = 1'b0;
      if (flush) begin
         state_d = ST_IDLE;
      end else begin
         unique case (state_q)
            ST_IDLE, ST_DONE: begin
               state_d = ST_IDLE;
               if (start) begin
                  a_d   = A;
                  b_d   = B;
                  sgn_d = in_sgn;
                  if (!in_div) begin
                     state_d = ST_MUL;
                     cnt_d   = MUL_CNT0;
                  end else if (B != '0) begin
                     state_d  = ST_DIV;
                     cnt_d    = DIV_CNT0;
                     div_load = 1'b1;
                  end else begin
                     state_d = ST_DONE;
                     hi_d    = A;
                     lo_d    = '1;
                  end
               end
            end
            ST_MUL: begin
               if (cnt_q == '0) begin
                  state_d = ST_DONE;
                  hi_d    = prod[63:32];
                  lo_d    = prod[31:0];
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
            ST_DIV: begin
               div_step = 1'b1;
               if (cnt_q == '0) begin
                  state_d = ST_DONE;
                  lo_d    = cond_neg(div_quot, sgn_q & (a_q[31] ^ b_q[31]));
                  hi_d    = cond_neg(div_rem, sgn_q & a_q[31]);
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         sgn_q   <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sgn_q   <= sgn_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   // DONE is left out so the issuing instruction retires on the done cycle
   assign busy = rst & ~flush &
                 ((state_q == ST_MUL) || (state_q == ST_DIV) || ((state_q == ST_IDLE) && start));
   assign done = (state_q == ST_DONE);
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: expected HI/LO and done cycle queued at issue, checked on done.
module tb_muldiv_ctrl;

   localparam int unsigned MUL_LAT = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  ALU2Op = '0;
   logic [31:0] A = '0;
   logic [31:0] B = '0;
   logic        flush = 1'b0;
   logic        busy, done;
   logic [31:0] hi, lo;

   muldiv_ctrl #(.MUL_LAT(MUL_LAT)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .ALU2Op (ALU2Op),
      .A      (A),
      .B      (B),
      .flush  (flush),
      .busy   (busy),
      .done   (done),
      .hi     (hi),
      .lo     (lo)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] res;
      int unsigned cyc;
   } exp_t;

   exp_t        sb_q[$];
   int unsigned cyc = 0;
   int unsigned n_tests = 0;
   int unsigned n_fail = 0;
   logic [63:0] last_res = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      longint      sa, sb, sq, sr;
      logic [63:0] p, tq, tr;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         2'b00: p = {32'd0, a} * {32'd0, b};
         2'b01: begin sq = sa * sb; p = sq; end
         2'b10: p = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
         default: begin
            if (b == 0) p = {a, 32'hFFFF_FFFF};
            else begin
               sq = sa / sb;
               sr = sa % sb;
               tq = sq;
               tr = sr;
               p  = {tr[31:0], tq[31:0]};
            end
         end
      endcase
      return p;
   endfunction

   function automatic int unsigned latency(input logic [1:0] op, input logic [31:0] b);
      if (!op[1]) return MUL_LAT + 1;
      if (b == 0) return 1;
      return 33;
   endfunction

   // Monitor: every done must match the oldest expectation, in value and cycle.
   always @(negedge clk) begin
      if (rst && done) begin
         if (sb_q.size() == 0) check("spurious_done", {63'd0, done}, 64'd0);
         else begin
            exp_t e;
            e = sb_q.pop_front();
            check("done_cycle", 64'(cyc), 64'(e.cyc));
            check("hilo", {hi, lo}, e.res);
            last_res = e.res;
         end
      end
   end

   // Caller is at a negedge; drives start for one cycle and returns at the next negedge.
   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] res, input logic exp_busy);
      exp_t e;
      start  = 1'b1;
      ALU2Op = op;
      A      = a;
      B      = b;
      #1;
      check("busy_issue", {63'd0, busy}, {63'd0, exp_busy});
      e.res = res;
      e.cyc = cyc + latency(op, b);
      sb_q.push_back(e);
      @(negedge clk);
      start  = 1'b0;
      ALU2Op = 2'($urandom);
      A      = $urandom;
      B      = $urandom;
   endtask

   task automatic drain();
      for (int i = 0; i < 100 && sb_q.size() != 0; i++) @(negedge clk);
      check("drain", 64'(sb_q.size()), 64'd0);
      @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [1:0]  op;
      logic [31:0] a, b;

      repeat (3) @(negedge clk);
      start = 1'b1;
      #1;
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_done", {63'd0, done}, 64'd0);
      check("rst_hilo", {hi, lo}, 64'd0);
      start = 1'b0;
      rst = 1'b1;
      @(negedge clk);

      // MULT with busy profile
      issue(2'b01, 32'hFFFF_FFFE, 32'd3, 64'hFFFF_FFFF_FFFF_FFFA, 1'b1);
      for (int k = 1; k <= int'(MUL_LAT); k++) begin
         check("mul_busy", {63'd0, busy}, 64'd1);
         @(negedge clk);
      end
      check("mul_busy_done", {63'd0, busy}, 64'd0);
      check("mul_done_seen", {63'd0, done}, 64'd1);
      drain();

      issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b1);
      drain();
      issue(2'b11, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b1);
      drain();
      issue(2'b10, 32'hFFFF_FFF9, 32'd2, 64'h0000_0001_7FFF_FFFC, 1'b1);
      drain();
      issue(2'b10, 32'd7, 32'd0, 64'h0000_0007_FFFF_FFFF, 1'b1);
      drain();
      issue(2'b11, 32'hFFFF_FFF0, 32'd0, 64'hFFFF_FFF0_FFFF_FFFF, 1'b1);
      drain();
      issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b1);
      drain();

      // Flush at cycle 10 of a DIV, then a fresh op the next cycle
      start = 1'b1; ALU2Op = 2'b10; A = 32'd100; B = 32'd7;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      flush = 1'b1;
      #1;
      check("flush_busy", {63'd0, busy}, 64'd0);
      check("flush_hilo", {hi, lo}, last_res);
      @(negedge clk);
      flush = 1'b0;
      check("flush_nodone", {63'd0, done}, 64'd0);
      check("flush_hilo_after", {hi, lo}, last_res);
      issue(2'b10, 32'd100, 32'd7, model(2'b10, 32'd100, 32'd7), 1'b1);
      drain();

      // Back-to-back: second op issued in the DONE cycle of the first
      issue(2'b00, 32'd12345, 32'd678, model(2'b00, 32'd12345, 32'd678), 1'b1);
      repeat (MUL_LAT) @(negedge clk);
      check("b2b_done", {63'd0, done}, 64'd1);
      issue(2'b11, 32'hFFFF_FF00, 32'd9, model(2'b11, 32'hFFFF_FF00, 32'd9), 1'b0);
      drain();

      // Async reset in the middle of a DIV
      issue(2'b10, 32'hDEAD_BEEF, 32'd13, 64'd0, 1'b1);
      repeat (5) @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_mid_busy", {63'd0, busy}, 64'd0);
      check("rst_mid_done", {63'd0, done}, 64'd0);
      check("rst_mid_hilo", {hi, lo}, 64'd0);
      sb_q.delete();
      last_res = '0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 12; i++) begin
         op = 2'($urandom_range(0, 3));
         a  = $urandom;
         case ($urandom_range(0, 4))
            0:       b = 32'd0;
            1:       b = 32'($urandom_range(1, 20));
            2:       b = 32'hFFFF_FFFF - 32'($urandom_range(0, 5));
            default: b = $urandom;
         endcase
         issue(op, a, b, model(op, a, b), 1'b1);
         drain();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
